mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/riscv_pkg.sv | 19 +
 rtl/load_extend.sv | 33 +++
 rtl/mem_wb_stage.sv | 139 +++++++++++++
 tb/tb_mem_wb_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings: writeback result select and load funct3 codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_ZERO = 2'b11
    } resultsrc_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Load alignment/extension: picks byte or halfword at the offset and sign/zero-extends.
// Latency: combinational.
// Backpressure: none.
module load_extend
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            off,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword lane uses off[1] only; off[0] is deliberately ignored.
    assign byte_sel = word[{off, 3'b000} +: 8];
    assign half_sel = off[1] ? word[31:16] : word[15:0];

    always_comb begin
        ext = word;
        unique case (funct3)
            F3_LB:   ext = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  ext = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            F3_LH:   ext = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            F3_LHU:  ext = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: ext = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register feeding the register-file write port; INSTRET_EN adds a 64-bit retire counter.
// Latency: one cycle from capture to A3/WD3/WE3 (WD3 combinational from the captured slot).
// Backpressure: m_ready = !wb_stall; stall holds the slot, flush kills it and overrides both.
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     m_valid,
    output logic                     m_ready,
    input  logic [ADDRESS_WIDTH-1:0] m_rd,
    input  logic                     m_regwrite,
    input  logic [1:0]               m_resultsrc,
    input  logic [2:0]               m_funct3,
    input  logic [DATA_WIDTH-1:0]    m_alu_result,
    input  logic [DATA_WIDTH-1:0]    m_read_data,
    input  logic [DATA_WIDTH-1:0]    m_pc_plus4,
    input  logic                     wb_stall,
    input  logic                     flush,
    output logic [ADDRESS_WIDTH-1:0] A3,
    output logic [DATA_WIDTH-1:0]    WD3,
    output logic                     WE3,
    output logic                     w_valid
`ifdef INSTRET_EN
    ,
    output logic [63:0]              instret
`endif
);

    logic                     valid_q, valid_d;
    logic [ADDRESS_WIDTH-1:0] rd_q, rd_d;
    logic                     regwrite_q, regwrite_d;
    resultsrc_e               resultsrc_q, resultsrc_d;
    logic [2:0]               funct3_q, funct3_d;
    logic [DATA_WIDTH-1:0]    alu_q, alu_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]    pc4_q, pc4_d;
    logic [DATA_WIDTH-1:0]    load_val;
    logic                     capture;

    assign m_ready = !wb_stall;
    assign capture = m_valid && m_ready;

    always_comb begin
        valid_d     = valid_q;
        rd_d        = rd_q;
        regwrite_d  = regwrite_q;
        resultsrc_d = resultsrc_q;
        funct3_d    = funct3_q;
        alu_d       = alu_q;
        rdata_d     = rdata_q;
        pc4_d       = pc4_q;
        if (m_ready) begin
            valid_d = m_valid;
        end
        if (capture) begin
            rd_d        = m_rd;
            regwrite_d  = m_regwrite;
            resultsrc_d = resultsrc_e'(m_resultsrc);
            funct3_d    = m_funct3;
            alu_d       = m_alu_result;
            rdata_d     = m_read_data;
            pc4_d       = m_pc_plus4;
        end
        // Flush only has to kill validity; the payload becomes don't-care.
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rd_q        <= '0;
            regwrite_q  <= 1'b0;
            resultsrc_q <= RES_ALU;
            funct3_q    <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
            pc4_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            rd_q        <= rd_d;
            regwrite_q  <= regwrite_d;
            resultsrc_q <= resultsrc_d;
            funct3_q    <= funct3_d;
            alu_q       <= alu_d;
            rdata_q     <= rdata_d;
            pc4_q       <= pc4_d;
        end
    end

    load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
        .word   (rdata_q),
        .off    (alu_q[1:0]),
        .funct3 (funct3_q),
        .ext    (load_val)
    );

    always_comb begin
        WD3 = '0;
        unique case (resultsrc_q)
            RES_ALU:  WD3 = alu_q;
            RES_LOAD: WD3 = load_val;
            RES_PC4:  WD3 = pc4_q;
            RES_ZERO: WD3 = '0;
            default:  WD3 = '0;
        endcase
    end

    assign A3      = rd_q;
    assign WE3     = valid_q && regwrite_q && (rd_q != '0);
    assign w_valid = valid_q;

`ifdef INSTRET_EN
    logic [63:0] instret_q, instret_d;

    always_comb begin
        instret_d = instret_q;
        if (valid_q && !wb_stall && !flush) begin
            instret_d = instret_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; retire-counter checks run when INSTRET_EN is defined.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_rd;
    logic        m_regwrite;
    logic [1:0]  m_resultsrc;
    logic [2:0]  m_funct3;
    logic [31:0] m_alu_result;
    logic [31:0] m_read_data;
    logic [31:0] m_pc_plus4;
    logic        wb_stall;
    logic        flush;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        WE3;
    logic        w_valid;
`ifdef INSTRET_EN
    logic [63:0] instret;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_rd         (m_rd),
        .m_regwrite   (m_regwrite),
        .m_resultsrc  (m_resultsrc),
        .m_funct3     (m_funct3),
        .m_alu_result (m_alu_result),
        .m_read_data  (m_read_data),
        .m_pc_plus4   (m_pc_plus4),
        .wb_stall     (wb_stall),
        .flush        (flush),
        .A3           (A3),
        .WD3          (WD3),
        .WE3          (WE3),
        .w_valid      (w_valid)
`ifdef INSTRET_EN
        ,
        .instret      (instret)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic [1:0] rs,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdat,
                         input logic [31:0] pc4);
        m_valid      = v;
        m_rd         = rd;
        m_regwrite   = rw;
        m_resultsrc  = rs;
        m_funct3     = f3;
        m_alu_result = alu;
        m_read_data  = rdat;
        m_pc_plus4   = pc4;
    endtask

    // One captured load: expected WD3 is hand-computed from word 0x80FF7F01.
    task automatic load_case(input string tag, input logic [2:0] f3, input logic [1:0] off,
                             input logic [31:0] exp);
        drive(1'b1, 5'd5, 1'b1, 2'b01, f3, {30'h0, off}, 32'h80FF7F01, 32'h0);
        tick();
        chk(tag, {32'h0, WD3}, {32'h0, exp});
    endtask

    initial begin
        rst_n    = 1'b0;
        wb_stall = 1'b0;
        flush    = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
        #3;
        chk("rst_w_valid", {63'h0, w_valid}, 64'h0);
        chk("rst_we3",     {63'h0, WE3},     64'h0);
        chk("rst_a3",      {59'h0, A3},      64'h0);
        chk("rst_wd3",     {32'h0, WD3},     64'h0);
        chk("rst_m_ready", {63'h0, m_ready}, 64'h1);
`ifdef INSTRET_EN
        chk("rst_instret", instret, 64'h0);
`endif
        #9 rst_n = 1'b1;
        tick();

        // LB at offset 2 of 0x80FF7F01 -> 0xFF sign-extended
        drive(1'b1, 5'd5, 1'b1, 2'b01, 3'b000, 32'h2, 32'h80FF7F01, 32'h0);
        tick();
        chk("lb_wd3",   {32'h0, WD3}, 64'hFFFF_FFFF);
        chk("lb_a3",    {59'h0, A3},  64'd5);
        chk("lb_we3",   {63'h0, WE3}, 64'h1);
        chk("lb_valid", {63'h0, w_valid}, 64'h1);

        load_case("lb_off1",    3'b000, 2'd1, 32'h0000_007F);
        load_case("lb_off3",    3'b000, 2'd3, 32'hFFFF_FF80);
        load_case("lbu_off3",   3'b100, 2'd3, 32'h0000_0080);
        load_case("lbu_off2",   3'b100, 2'd2, 32'h0000_00FF);
        load_case("lhu_off2",   3'b101, 2'd2, 32'h0000_80FF);
        load_case("lh_off0",    3'b001, 2'd0, 32'h0000_7F01);
        load_case("lh_off3",    3'b001, 2'd3, 32'hFFFF_80FF);
        load_case("lhu_off1",   3'b101, 2'd1, 32'h0000_7F01);
        load_case("lw",         3'b010, 2'd0, 32'h80FF_7F01);
        load_case("f3_other",   3'b011, 2'd2, 32'h80FF_7F01);

        // result select: PC+4 and the zero code
        drive(1'b1, 5'd1, 1'b1, 2'b10, 3'b000, 32'h55, 32'h66, 32'h100);
        tick();
        chk("sel_pc4", {32'h0, WD3}, 64'h100);
        drive(1'b1, 5'd1, 1'b1, 2'b11, 3'b000, 32'h55, 32'h66, 32'h100);
        tick();
        chk("sel_zero", {32'h0, WD3}, 64'h0);
        drive(1'b1, 5'd2, 1'b0, 2'b00, 3'b000, 32'h77, 32'h0, 32'h0);
        tick();
        chk("no_regwrite_we3", {63'h0, WE3}, 64'h0);
        chk("no_regwrite_wd3", {32'h0, WD3}, 64'h77);

        // stall holds the slot while inputs keep changing
        drive(1'b1, 5'd3, 1'b1, 2'b00, 3'b000, 32'h1234, 32'h0, 32'h0);
        tick();
        chk("alu_wd3", {32'h0, WD3}, 64'h1234);
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(7 + i), 1'b1, 2'b10, 3'b010, 32'hDEAD_0000 + i, 32'hBEEF, 32'h4444);
            #1;
            chk("stall_m_ready", {63'h0, m_ready}, 64'h0);
            tick();
            chk("stall_wd3", {32'h0, WD3}, 64'h1234);
            chk("stall_a3",  {59'h0, A3},  64'd3);
            chk("stall_we3", {63'h0, WE3}, 64'h1);
        end

        // flush beats stall and capture
        flush = 1'b1;
        tick();
        chk("flush_valid", {63'h0, w_valid}, 64'h0);
        chk("flush_we3",   {63'h0, WE3},     64'h0);
        flush    = 1'b0;
        wb_stall = 1'b0;

        drive(1'b1, 5'd0, 1'b1, 2'b00, 3'b000, 32'h9, 32'h0, 32'h0);
        tick();
        chk("rd0_valid", {63'h0, w_valid}, 64'h1);
        chk("rd0_we3",   {63'h0, WE3},     64'h0);

        m_valid = 1'b0;
        tick();
        chk("bubble_valid", {63'h0, w_valid}, 64'h0);

        // asynchronous reset mid-cycle
        drive(1'b1, 5'd9, 1'b1, 2'b00, 3'b000, 32'hAB, 32'h0, 32'h0);
        tick();
        chk("pre_rst_we3", {63'h0, WE3}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we3",   {63'h0, WE3},     64'h0);
        chk("arst_valid", {63'h0, w_valid}, 64'h0);
        chk("arst_a3",    {59'h0, A3},      64'h0);
        #1 rst_n = 1'b1;
        m_valid = 1'b0;
        tick();
        chk("post_rst_idle", {63'h0, w_valid}, 64'h0);
        m_valid = 1'b1;
        tick();
        chk("post_rst_cap", {63'h0, w_valid}, 64'h1);
        chk("post_rst_a3",  {59'h0, A3},      64'd9);

`ifdef INSTRET_EN
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        m_valid = 1'b1;
        // 10 captures: the first only fills the slot, the next 9 each retire one
        for (int i = 0; i < 10; i++) begin
            m_rd = 5'(i + 1);
            tick();
        end
        chk("ir_after_captures", instret, 64'd9);
        m_valid  = 1'b0;
        wb_stall = 1'b1;
        tick();
        tick();
        chk("ir_after_stall", instret, 64'd9);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        wb_stall = 1'b0;
        chk("ir_after_flush", instret, 64'd9);
        m_valid = 1'b1;
        tick();
        m_valid = 1'b0;
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.instret_q;
        tick();
        chk("ir_wrap", instret, 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
